// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register.
// Carries a payload bundle and a side-effect control bundle through STAGES
// register slots. Each slot has valid/ready flow control, bubble collapsing,
// stall hold and a synchronous flush. A bubble forces the controls to NOP
// (all-zero) while its payload keeps the last value seen.
// Optional build macro: PIPE_STATS_EN adds saturating stall/flush counters.
module pipe_stage_reg #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8,
  parameter int STAGES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  // Per-slot state: valid bit, payload, side-effect controls.
  logic [STAGES-1:0] v;
  logic [DATA_W-1:0] d [STAGES];
  logic [CTRL_W-1:0] c [STAGES];

  // Move enables and the entry each slot would load from upstream.
  logic [STAGES-1:0] mv;
  logic [STAGES-1:0] up_v;
  logic [DATA_W-1:0] up_d [STAGES];
  logic [CTRL_W-1:0] up_c [STAGES];

  // Slot i may move when the output drains or any slot from i onward is
  // empty; written as a scan so the chain has no self-referencing vector.
  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    mv = '0;
    for (int i = 0; i < STAGES; i++) begin
      mv[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!v[j]) mv[i] = 1'b1;
      end
    end
  end

  // Upstream source of each slot: the input port for slot 0, the previous slot otherwise.
  always_comb begin
    up_v    = '0;
    up_v[0] = in_valid;
    up_d[0] = in_data;
    up_c[0] = in_ctrl;
    for (int i = 1; i < STAGES; i++) begin
      up_v[i] = v[i-1];
      up_d[i] = d[i-1];
      up_c[i] = c[i-1];
    end
  end

  // Slot registers: reset clears everything, flush kills valids and controls,
  // otherwise each slot loads when it can move and holds when stalled.
  // NOTE: sequential state uses non-blocking assignments so every slot
  // samples its neighbour's pre-edge value and the shift is order-independent.
  // NOTE: the payload array is reset too, because out_data must read zero
  // after reset; a payload that may stay undefined would skip this.
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
    end else if (flush) begin
      v <= '0;
      for (int i = 0; i < STAGES; i++) c[i] <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (mv[i]) begin
          v[i] <= up_v[i];
          if (up_v[i]) begin
            d[i] <= up_d[i];
            c[i] <= up_c[i];
          end else begin
            c[i] <= '0;
          end
        end
      end
    end
  end

  // Only in_ready is combinational; the out_* ports come straight from the last slot.
  assign in_ready  = mv[0] && !flush;
  assign out_valid = v[STAGES-1];
  assign out_data  = d[STAGES-1];
  assign out_ctrl  = c[STAGES-1];

`ifdef PIPE_STATS_EN
  // Saturating event counters for output stalls and flush pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (flush && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: bench for pipe_stage_reg. Three instances (STAGES=1,2,3)
// share one stimulus stream. Each instance is followed by a model that keeps
// the in-flight entries as an ordered list with slot positions, plus a
// hand-derived vector table for STAGES=2 and hand sequences for STAGES=3.
module tb_pipe_stage_reg;
  localparam int NI = 3;
  localparam int DW = 96;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, flush, out_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic [NI-1:0] ir, ov;
  logic [DW-1:0] od [NI];
  logic [CW-1:0] oc [NI];
`ifdef PIPE_STATS_EN
  logic [31:0]   sc [NI];
  logic [31:0]   fc [NI];
`endif

  for (genvar g = 0; g < NI; g++) begin : g_dut
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .STAGES(g + 1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[g]),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(ov[g]), .out_ready(out_ready), .out_data(od[g]), .out_ctrl(oc[g])
`ifdef PIPE_STATS_EN
      , .stall_cnt(sc[g]), .flush_cnt(fc[g])
`endif
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: for each instance an ordered list (oldest first) of
  // entries, each with its current slot position.
  int            m_cnt  [NI];
  int            m_pos  [NI][4];
  logic [DW-1:0] m_d    [NI][4];
  logic [CW-1:0] m_c    [NI][4];
  logic [DW-1:0] m_last [NI];
  logic [31:0]   m_sc   [NI];
  logic [31:0]   m_fc   [NI];
  bit            m_known = 1'b0;
  logic [NI-1:0] ir_snap;

  function automatic bit m_ov(input int i);
    return (m_cnt[i] > 0) && (m_pos[i][0] == i);
  endfunction

  // Room exists if fewer entries than slots are held, or the output drains.
  function automatic bit m_ir(input int i);
    return ((m_cnt[i] < i + 1) || out_ready) && !flush;
  endfunction

  task automatic model_edge();
    for (int i = 0; i < NI; i++) begin
      int s = i + 1;
      int bound;
      bit acc;
      if (rst) begin
        m_cnt[i] = 0; m_last[i] = '0; m_sc[i] = '0; m_fc[i] = '0;
        continue;
      end
      if (m_ov(i) && !out_ready && m_sc[i] != 32'hFFFF_FFFF) m_sc[i]++;
      if (flush) begin
        if (m_fc[i] != 32'hFFFF_FFFF) m_fc[i]++;
        m_cnt[i] = 0;
        continue;
      end
      acc = in_valid && m_ir(i);
      if (m_ov(i) && out_ready) begin
        for (int k = 1; k < m_cnt[i]; k++) begin
          m_pos[i][k-1] = m_pos[i][k]; m_d[i][k-1] = m_d[i][k]; m_c[i][k-1] = m_c[i][k];
        end
        m_cnt[i]--;
      end
      // Each entry advances one slot unless blocked by the entry ahead of it.
      bound = s;
      for (int k = 0; k < m_cnt[i]; k++) begin
        int np = (m_pos[i][k] + 1 < bound - 1) ? m_pos[i][k] + 1 : bound - 1;
        m_pos[i][k] = np;
        bound = np;
        if (np == s - 1) m_last[i] = m_d[i][k];
      end
      if (acc) begin
        m_pos[i][m_cnt[i]] = 0; m_d[i][m_cnt[i]] = in_data; m_c[i][m_cnt[i]] = in_ctrl;
        if (s == 1) m_last[i] = in_data;
        m_cnt[i]++;
      end
    end
    if (rst) m_known = 1'b1;
  endtask

  // One clock cycle: drive at the falling edge, check in_ready before the
  // rising edge, advance the model, check registered outputs just after it.
  task automatic step(input bit rv, input bit iv, input logic [DW-1:0] dd,
                      input logic [CW-1:0] cc, input bit fl, input bit ordy);
    rst = rv; in_valid = iv; in_data = dd; in_ctrl = cc; flush = fl; out_ready = ordy;
    #1;
    ir_snap = ir;
    if (m_known)
      for (int i = 0; i < NI; i++)
        check($sformatf("s%0d in_ready", i + 1), 128'(ir[i]), 128'(m_ir(i)));
    model_edge();
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      check($sformatf("s%0d out_valid", i + 1), 128'(ov[i]), 128'(m_ov(i)));
      check($sformatf("s%0d out_data", i + 1), 128'(od[i]), 128'(m_last[i]));
      check($sformatf("s%0d out_ctrl", i + 1), 128'(oc[i]), 128'(m_ov(i) ? m_c[i][0] : 8'h00));
`ifdef PIPE_STATS_EN
      check($sformatf("s%0d stall_cnt", i + 1), 128'(sc[i]), 128'(m_sc[i]));
      check($sformatf("s%0d flush_cnt", i + 1), 128'(fc[i]), 128'(m_fc[i]));
`endif
    end
    @(negedge clk);
  endtask

  // Hand-derived vectors; expectations are for the STAGES=2 instance.
  typedef struct {
    bit            rv, iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    bit            fl, ordy, chk_ir, e_ir, e_ov;
    logic [DW-1:0] e_od;
    logic [CW-1:0] e_oc;
  } vec_t;

  function automatic vec_t mk(bit rv, bit iv, logic [DW-1:0] d, logic [CW-1:0] c, bit fl,
                              bit ordy, bit chk, bit eir, bit eov, logic [DW-1:0] eod,
                              logic [CW-1:0] eoc);
    vec_t r;
    r.rv = rv; r.iv = iv; r.d = d; r.c = c; r.fl = fl; r.ordy = ordy;
    r.chk_ir = chk; r.e_ir = eir; r.e_ov = eov; r.e_od = eod; r.e_oc = eoc;
    return r;
  endfunction

  vec_t tbl [17];

  initial begin
    //            rv iv data   ctrl   fl rdy chk ir ov out_data ctrl
    tbl[0]  = mk(1, 0, 96'h0,  8'h00, 0, 0,  0, 0, 0, 96'h0,  8'h00); // reset
    tbl[1]  = mk(0, 1, 96'h1,  8'h11, 0, 1,  1, 1, 0, 96'h0,  8'h00); // stream
    tbl[2]  = mk(0, 1, 96'h2,  8'h12, 0, 1,  1, 1, 1, 96'h1,  8'h11);
    tbl[3]  = mk(0, 1, 96'h3,  8'h13, 0, 1,  1, 1, 1, 96'h2,  8'h12);
    tbl[4]  = mk(0, 0, 96'hAA, 8'hFF, 0, 1,  1, 1, 1, 96'h3,  8'h13); // bubble kill
    tbl[5]  = mk(0, 0, 96'hAA, 8'hFF, 0, 1,  1, 1, 0, 96'h3,  8'h00);
    tbl[6]  = mk(0, 0, 96'h0,  8'h00, 0, 1,  1, 1, 0, 96'h3,  8'h00);
    tbl[7]  = mk(0, 1, 96'h21, 8'h05, 0, 1,  1, 1, 0, 96'h3,  8'h00); // flush mid-stream
    tbl[8]  = mk(0, 1, 96'h22, 8'h05, 0, 1,  1, 1, 1, 96'h21, 8'h05);
    tbl[9]  = mk(0, 1, 96'h23, 8'h05, 1, 0,  1, 0, 0, 96'h21, 8'h00);
    tbl[10] = mk(0, 0, 96'h0,  8'h00, 0, 1,  1, 1, 0, 96'h21, 8'h00);
    tbl[11] = mk(0, 0, 96'h0,  8'h00, 0, 1,  1, 1, 0, 96'h21, 8'h00);
    tbl[12] = mk(0, 1, 96'h31, 8'h07, 0, 0,  1, 1, 0, 96'h21, 8'h00); // fill, then reset+flush
    tbl[13] = mk(0, 1, 96'h32, 8'h07, 0, 0,  1, 1, 1, 96'h31, 8'h07);
    tbl[14] = mk(0, 1, 96'h33, 8'h07, 0, 0,  1, 0, 1, 96'h31, 8'h07);
    tbl[15] = mk(1, 1, 96'h34, 8'h07, 1, 0,  1, 0, 0, 96'h0,  8'h00);
    tbl[16] = mk(0, 0, 96'h0,  8'h00, 0, 1,  1, 1, 0, 96'h0,  8'h00);

    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = '0; in_ctrl = '0;
    @(negedge clk);

    for (int r = 0; r < 17; r++) begin
      step(tbl[r].rv, tbl[r].iv, tbl[r].d, tbl[r].c, tbl[r].fl, tbl[r].ordy);
      if (tbl[r].chk_ir)
        check($sformatf("tbl%0d in_ready", r), 128'(ir_snap[1]), 128'(tbl[r].e_ir));
      check($sformatf("tbl%0d out_valid", r), 128'(ov[1]), 128'(tbl[r].e_ov));
      check($sformatf("tbl%0d out_data", r), 128'(od[1]), 128'(tbl[r].e_od));
      check($sformatf("tbl%0d out_ctrl", r), 128'(oc[1]), 128'(tbl[r].e_oc));
`ifdef PIPE_STATS_EN
      if (r == 15) check("rst+flush flush_cnt", 128'(fc[1]), 128'(0));
`endif
    end

    // Backpressure on STAGES=3: five pushes with out_ready low, three accepted.
    step(1, 0, '0, '0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(0, 1, DW'(32'h51 + k), 8'h09, 0, 0);
      check($sformatf("bp push%0d in_ready", k), 128'(ir_snap[2]), 128'(k < 3));
    end
    check("bp full out_data", 128'(od[2]), 128'(96'h51));
    check("bp full out_valid", 128'(ov[2]), 128'(1));
    step(0, 0, '0, '0, 0, 1);
    check("bp release in_ready", 128'(ir_snap[2]), 128'(1));
    check("bp drain1 out_data", 128'(od[2]), 128'(96'h52));
    step(0, 0, '0, '0, 0, 1);
    check("bp drain2 out_data", 128'(od[2]), 128'(96'h53));
    step(0, 0, '0, '0, 0, 1);
    check("bp empty out_valid", 128'(ov[2]), 128'(0));

    // Stats on STAGES=2: four stalled edges with a valid output, two flushes.
    step(1, 0, '0, '0, 0, 0);
    step(0, 1, 96'h41, 8'h03, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, '0, '0, 0, 0);
    step(0, 0, '0, '0, 1, 1);
    step(0, 0, '0, '0, 1, 1);
    check("stats out_valid after flush", 128'(ov[1]), 128'(0));
`ifdef PIPE_STATS_EN
    check("stats stall_cnt", 128'(sc[1]), 128'(4));
    check("stats flush_cnt", 128'(fc[1]), 128'(2));
`endif

    // Randomised traffic with occasional flush and reset.
    for (int n = 0; n < 800; n++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 99) < 60,
           {$urandom, $urandom, $urandom}, CW'($urandom),
           $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 65);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
